pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Consumer side of the hazard-request path in the RV32I 5-stage pipeline.
- Takes the load-use hazard request from the ID-stage detector, the taken-branch/jump flag from EX, and the data-memory handshake from MEM.
- Resolves them by fixed priority into per-stage stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Tracks multi-cycle memory waits with an FSM and timeout, and keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, consecutive memory-wait cycles tolerated before the block enters ERR (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- load_hazard  input  1  load-use hazard detected between EX load and ID consumer.
- pc_src_e  input  1  taken branch/jump resolved in EX.
- dmem_req_m  input  1  MEM-stage instruction is accessing data memory.
- dmem_ready  input  1  data memory completes the access this cycle.
- stall_f  output  1  hold PC.
- pc_write  output  1  equals ~stall_f; active-high PC write enable.
- stall_d  output  1  hold IF/ID.
- stall_e  output  1  hold ID/EX.
- stall_m  output  1  hold EX/MEM.
- flush_d  output  1  clear IF/ID to NOP.
- flush_e  output  1  clear ID/EX to NOP (bubble).
- flush_w  output  1  clear MEM/WB to NOP.
- mem_wait  output  1  FSM is in WAIT.
- mem_timeout  output  1  sticky error; FSM is in ERR.
- stall_cnt  output  CNT_W  cycles with stall_f=1, saturating.
- flush_cnt  output  CNT_W  cycles with flush_e=1, saturating.

Behaviour:
- All stall/flush outputs are combinational from the current state and inputs, so they act in the same cycle. The FSM, wait counter and performance counters are registered.
- Define mem_stall = (state != ERR) & dmem_req_m & ~dmem_ready, OR state == ERR.
- Priority 1, mem_stall:
  - stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1.
  - flush_d = flush_e = 0.
  - pc_src_e and load_hazard are ignored. EX is held, so pc_src_e is re-evaluated after release.
- Priority 2, pc_src_e (no mem_stall):
  - flush_d = flush_e = 1, all stalls 0.
  - load_hazard is ignored because the ID instruction is discarded.
- Priority 3, load_hazard (no mem_stall, no pc_src_e):
  - stall_f = stall_d = 1, flush_e = 1.
  - stall_e = stall_m = 0, flush_d = flush_w = 0.
- Otherwise all stall/flush outputs are 0 and pc_write = 1.
- FSM states IDLE, WAIT, ERR, with wait_cnt of width ceil(log2(MEM_TIMEOUT+1)).
  - IDLE: if dmem_req_m & ~dmem_ready, go to WAIT with wait_cnt=1. Otherwise stay.
  - WAIT, dmem_ready=1 or dmem_req_m=0: go to IDLE, wait_cnt=0. A dropped request is tolerated with no error.
  - WAIT, still req & ~ready, wait_cnt == MEM_TIMEOUT: go to ERR.
  - WAIT, still req & ~ready, otherwise: wait_cnt+1.
  - ERR: absorbing until rst. mem_timeout=1 and full pipeline stall is held.
  - mem_wait = (state == WAIT).
- Zero-wait access (req & ready in the same cycle) causes no stall and no state change.
- Timeout timing: with MEM_TIMEOUT=N and ready never arriving, there are N+1 stalled cycles (IDLE cycle plus N in WAIT), then ERR from the next edge. Ready arriving on any of those cycles prevents ERR.
- Counters increment by 1 per qualifying cycle and hold at all-ones. The ERR state keeps counting stall_cnt until saturation.
- Reset (dominates every other input, mid-wait or in ERR):
  - state=IDLE, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs then follow the inputs with state IDLE, so with inputs idle: stalls/flushes 0, pc_write=1, mem_wait=0.

Test Plan:
- load_hazard=1 for 1 cycle, others 0 -> stall_f=stall_d=flush_e=1, pc_write=0, stall_e=0; stall_cnt=1, flush_cnt=1 afterwards.
- load_hazard=1 and pc_src_e=1 together -> flush_d=flush_e=1, stall_f=0, pc_write=1; stall_cnt unchanged.
- dmem_req_m=1, ready low 3 cycles then high (MEM_TIMEOUT=16):
  - stall_f..stall_m=1 and flush_w=1 for 3 cycles; mem_wait=1 for cycles 2-4.
  - Returns to IDLE after ready; stall_cnt=3.
- pc_src_e=1 and load_hazard=1 during a 2-cycle memory wait -> only stalls plus flush_w during the wait; flush_d=flush_e=1 on the release cycle.
- MEM_TIMEOUT=4, req=1 and ready=0 held -> 5 stalled cycles, then mem_timeout=1 and stall held even after req drops; rst=1 for 1 cycle -> all outputs at reset values.
- Force 2^CNT_W-1 stall cycles (CNT_W=4: 20 load hazards) -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Hazard-request consumer for the 5-stage pipeline: priority-resolves memory waits,
// taken branches and load-use hazards into per-stage stall/flush controls.
module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_hazard,
   input  logic             pc_src_e,
   input  logic             dmem_req_m,
   input  logic             dmem_ready,
   output logic             stall_f,
   output logic             pc_write,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             mem_wait,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
   logic           dmem_miss;
   logic           mem_stall;

   assign dmem_miss = dmem_req_m & ~dmem_ready;
   assign mem_stall = (state == ERR) | dmem_miss;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (dmem_miss) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = WCW'(1);
            end
         end
         WAIT: begin
            // A dropped request releases the wait just like a completed one.
            if (!dmem_miss) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
               state_nxt = ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + WCW'(1);
            end
         end
         ERR:     state_nxt = ERR;
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (mem_stall) begin
         // EX is frozen, so a pending branch is simply re-seen after release.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (pc_src_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_hazard) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   assign pc_write    = ~stall_f;
   assign mem_wait    = (state == WAIT);
   assign mem_timeout = (state == ERR);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_e && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
